// File: rtl/branch_predictor_table_ctrl.sv
// -----------------------------------------------------------------------------
// branch_predictor_table_ctrl
//
// A table of 2-bit saturating branch counters indexed by PC[IDX_BITS+1:2].
// It serves one IF-stage prediction lookup per cycle with 1-cycle latency.
// Resolved-branch outcomes arrive from EX through a valid/ready update FIFO.
// One queued update is retired into the table each cycle.
// After init_i, a CLEAR/RUN FSM sweeps every counter to INIT_STATE.
//
// Optional feature macro: BP_BYPASS_EN
//   Defined   : a lookup that hits the entry being drained in the same cycle
//               sees the post-update counter.
//   Undefined : that lookup sees the stale (pre-update) counter.
//   The table contents are identical in both builds.
//
// Ports
//   clock_i          clock, all state changes on posedge
//   init_i           synchronous active-high reset / re-initialise
//   lookup_valid_i   prediction request this cycle
//   lookup_pc_i      PC of the fetched instruction
//   pred_valid_o     registered, prediction_o is meaningful
//   prediction_o     registered, 1 = predict taken
//   upd_valid_i      resolved-branch update offered
//   upd_pc_i         PC of the resolved branch
//   upd_outcome_i    1 = branch was taken
//   upd_ready_o      update FIFO can accept this cycle
//   busy_o           high while the clear sweep runs
// -----------------------------------------------------------------------------
module branch_predictor_table_ctrl #(
  parameter int unsigned IDX_BITS   = 4,
  parameter int unsigned UPD_DEPTH  = 4,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic        clock_i,
  input  logic        init_i,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  output logic        pred_valid_o,
  output logic        prediction_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_outcome_i,
  output logic        upd_ready_o,
  output logic        busy_o
);
  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam int unsigned AW      = $clog2(UPD_DEPTH);
  localparam int unsigned CW      = AW + 1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  logic [1:0]          table_q [ENTRIES];
  logic [IDX_BITS:0]   fifo_q  [UPD_DEPTH];   // {index, taken}
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q;
  logic                pred_valid_q, prediction_q;

  logic [IDX_BITS-1:0] lk_idx, up_idx, head_idx;
  logic                head_taken, push, pop;
  logic [1:0]          head_new, lk_cnt;
  logic                unused_pc_bits;

  function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else       return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  assign lk_idx     = lookup_pc_i[IDX_BITS+1:2];
  assign up_idx     = upd_pc_i[IDX_BITS+1:2];
  assign head_idx   = fifo_q[rd_q][IDX_BITS:1];
  assign head_taken = fifo_q[rd_q][0];
  assign head_new   = sat_cnt(table_q[head_idx], head_taken);

  // Ready comes from the registered count only, so a pop in the same cycle
  // never re-opens a full FIFO.
  assign push = upd_valid_i & upd_ready_o;
  // An entry is counted only after the edge that pushed it, so it is applied
  // at the earliest one cycle after its push.
  assign pop  = (state_q == RUN) && (cnt_q != '0);

`ifdef BP_BYPASS_EN
  assign lk_cnt = (pop && (head_idx == lk_idx)) ? head_new : table_q[lk_idx];
`else
  assign lk_cnt = table_q[lk_idx];
`endif

  assign unused_pc_bits = ^{lookup_pc_i[31:IDX_BITS+2], lookup_pc_i[1:0],
                            upd_pc_i[31:IDX_BITS+2], upd_pc_i[1:0]};

  // FSM next state and outputs
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    busy_o      = 1'b0;
    upd_ready_o = 1'b0;
    case (state_q)
      CLEAR: begin
        busy_o = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (&ptr_q) state_d = RUN;
      end
      RUN: begin
        upd_ready_o = (cnt_q < CW'(UPD_DEPTH));
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (init_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock_i) begin
    if (init_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) fifo_q[wr_q] <= {up_idx, upd_outcome_i};
  end

  // Table write: sweep in CLEAR, drain in RUN; init discards the pending head.
  always_ff @(posedge clock_i) begin
    if (!init_i) begin
      if (state_q == CLEAR) table_q[ptr_q]    <= INIT_STATE;
      else if (pop)         table_q[head_idx] <= head_new;
    end
  end

  // Prediction register
  always_ff @(posedge clock_i) begin
    if (init_i) begin
      pred_valid_q <= 1'b0;
      prediction_q <= 1'b0;
    end else if ((state_q == RUN) && lookup_valid_i) begin
      pred_valid_q <= 1'b1;
      prediction_q <= lk_cnt[1];
    end else begin
      pred_valid_q <= 1'b0;
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign prediction_o = prediction_q;
endmodule

// File: tb/tb_branch_predictor_table_ctrl.sv
module tb_branch_predictor_table_ctrl;
  localparam int N     = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        init = 1'b0, lv = 1'b0, uv = 1'b0, uo = 1'b0;
  logic [31:0] lpc = '0, upc = '0;
  logic        pred_valid_o, prediction_o, upd_ready_o, busy_o;

  always #5 clk = ~clk;

  branch_predictor_table_ctrl dut (
    .clock_i        (clk),
    .init_i         (init),
    .lookup_valid_i (lv),
    .lookup_pc_i    (lpc),
    .pred_valid_o   (pred_valid_o),
    .prediction_o   (prediction_o),
    .upd_valid_i    (uv),
    .upd_pc_i       (upc),
    .upd_outcome_i  (uo),
    .upd_ready_o    (upd_ready_o),
    .busy_o         (busy_o)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int tag; bit pred; } exp_t;
  typedef struct { int idx; bit taken; } upd_t;
  exp_t expq[$];
  upd_t pend[$];
  int   cnt_m [N];
  int   sweep_left = 0;
  bit   known = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[5:2]);
  endfunction

  function automatic int next_cnt(input int c, input bit taken);
    if (taken) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // One clock of stimulus; the reference model advances to the coming edge.
  task automatic tick(input bit i_init, input bit i_lv, input logic [31:0] i_lpc,
                      input bit i_uv, input logic [31:0] i_upc, input bit i_uo,
                      output bit accepted);
    bit m_ready;
    accepted = 0;
    @(negedge clk);
    m_ready = (sweep_left == 0) && (pend.size() < DEPTH);
    if (known) begin
      check("busy", busy_o, (sweep_left > 0));
      check("upd_ready", upd_ready_o, m_ready);
    end
    init = i_init; lv = i_lv; lpc = i_lpc; uv = i_uv; upc = i_upc; uo = i_uo;
    if (i_init) begin
      pend.delete();
      sweep_left = N;
      known = 1;
    end else if (known && sweep_left > 0) begin
      cnt_m[N - sweep_left] = 1;
      sweep_left--;
    end else if (known) begin
      int  li = idx_of(i_lpc);
      bit  drain = (pend.size() > 0);
      upd_t head;
      int  newc = 0;
      bit  pred;
      if (drain) begin
        head = pend[0];
        newc = next_cnt(cnt_m[head.idx], head.taken);
      end
      pred = (cnt_m[li] >= 2);
`ifdef BP_BYPASS_EN
      if (drain && head.idx == li) pred = (newc >= 2);
`endif
      if (i_lv) expq.push_back('{cyc + 1, pred});
      if (drain) begin
        cnt_m[head.idx] = newc;
        void'(pend.pop_front());
      end
      if (i_uv && m_ready) begin
        pend.push_back('{idx_of(i_upc), i_uo});
        accepted = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) tick(0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic look(input logic [31:0] pc);
    bit a;
    tick(0, 1, pc, 0, 0, 0, a);
  endtask

  task automatic upd(input logic [31:0] pc, input bit o);
    bit a = 0;
    for (int t = 0; t < 64 && !a; t++) tick(0, 0, 0, 1, pc, o, a);
    if (!a) check("upd_accept_timeout", 0, 1);
  endtask

  task automatic do_init();
    bit a;
    tick(1, 0, 0, 0, 0, 0, a);
  endtask

  task automatic sweep_with_lookups();
    bit a;
    for (int k = 0; k < N; k++) tick(0, 1, 32'(k * 4), 1, 32'h40, 1, a);
  endtask

  task automatic read_all();
    for (int k = 0; k < N; k++) look(32'(k * 4));
  endtask

  // Monitor: pops expected predictions whenever the DUT presents one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (expq.size() > 0 && expq[0].tag < cyc) begin
        n_cmp++; n_err++;
        $display("FAIL pred_missing @cyc %0d: got no pred_valid, expected one at cyc %0d",
                 cyc, expq[0].tag);
        void'(expq.pop_front());
      end
      if (pred_valid_o === 1'b1) begin
        if (expq.size() > 0 && expq[0].tag == cyc) begin
          check("prediction", prediction_o, expq[0].pred);
          void'(expq.pop_front());
        end else begin
          n_cmp++; n_err++;
          $display("FAIL pred_valid_unexpected @cyc %0d: got 1, expected 0", cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          a;
    bit          have;
    logic [31:0] hpc;
    bit          ho;

    // Reset sweep with lookups ignored, then every entry weakly not-taken
    do_init();
    sweep_with_lookups();
    read_all();

    // Train PC 0x40 up then down
    upd(32'h40, 1); upd(32'h40, 1); idle(2); look(32'h40);
    upd(32'h40, 0); upd(32'h40, 0); upd(32'h40, 0); idle(2); look(32'h40);

    // Saturation and aliasing
    for (int k = 0; k < 6; k++) upd(32'h8, 1);
    upd(32'h8, 0); idle(2); look(32'h8); look(32'h48);

    // Back-to-back burst
    for (int k = 0; k < 10; k++) upd(32'($urandom_range(0, 15) * 4), 1'($urandom));
    idle(3); read_all();

    // Lookup in the drain cycle of the same index
    do_init(); idle(N + 1);
    upd(32'hC, 1); look(32'hC); look(32'hC);

    // Init with pending update and active lookup
    upd(32'h10, 1);
    tick(1, 1, 32'h10, 1, 32'h14, 1, a);
    sweep_with_lookups();
    read_all();

    // Randomized traffic with held updates and occasional re-init
    have = 0; hpc = '0; ho = 0;
    for (int k = 0; k < 2000; k++) begin
      bit ri;
      if (!have && ($urandom_range(0, 2) != 0)) begin
        have = 1;
        hpc  = $urandom & 32'h7F;
        ho   = 1'($urandom);
      end
      ri = ($urandom_range(0, 299) == 0);
      tick(ri, 1'($urandom), $urandom & 32'h7F, have, hpc, ho, a);
      if (a) have = 0;
    end
    idle(N + 4);
    read_all();

    idle(3);
    check("leftover_expected", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
